// File: rtl/util_input_cond_pkg.sv
// Shared constants and helpers for the input conditioner: synchroniser depth
// limits and a counter-width function.
package util_input_cond_pkg;

    localparam int UTIL_SYNC_MIN = 2;
    localparam int UTIL_SYNC_MAX = 4;
    localparam int UTIL_DEB_MIN  = 1;
    localparam int UTIL_DEB_MAX  = 65535;

    // Bits needed to hold 0..value-1, never less than one so a counter always exists.
    function automatic int util_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/util_input_cond_chan.sv
// One conditioner channel: synchroniser chain, tick-gated debounce counter,
// debounced level and registered edge pulses.
module util_input_cond_chan
    import util_input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RES_VAL         = 1'b0
) (
    input  logic clk,
    input  logic res_n,
    input  logic tick,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic accept_next
);

    localparam int               CNT_W    = util_clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   accept;

    assign s           = sync[SYNC_STAGES-1];
    assign accept      = (s != q) && tick && (cnt == CNT_LAST);
    assign accept_next = accept;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync <= {SYNC_STAGES{RES_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
        end
    end

    // The counter only runs while s disagrees with q, so it is capped by the accept and never wraps.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt  <= '0;
            q    <= RES_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept & s;
            fall <= accept & ~s;
            if (s == q) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_LAST) begin
                    q   <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/util_input_cond.sv
// Multi-channel input conditioner: WIDTH independent debounced channels plus a
// registered "any edge" flag aligned with the rise/fall pulses.
module util_input_cond
    import util_input_cond_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RES_VAL         = '0
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] accept_next;

    if (SYNC_STAGES < UTIL_SYNC_MIN || SYNC_STAGES > UTIL_SYNC_MAX) begin : g_bad_sync
        $error("util_input_cond: SYNC_STAGES out of range 2..4");
    end
    if (DEBOUNCE_CYCLES < UTIL_DEB_MIN || DEBOUNCE_CYCLES > UTIL_DEB_MAX) begin : g_bad_deb
        $error("util_input_cond: DEBOUNCE_CYCLES out of range 1..65535");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        util_input_cond_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RES_VAL         (RES_VAL[i])
        ) u_chan (
            .clk         (clk),
            .res_n       (res_n),
            .tick        (tick),
            .d           (d[i]),
            .q           (q[i]),
            .rise        (rise[i]),
            .fall        (fall[i]),
            .accept_next (accept_next[i])
        );
    end

    // Registered from the channels' accept terms so it lands in the same cycle as rise/fall.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            changed <= 1'b0;
        end else begin
            changed <= |accept_next;
        end
    end

endmodule

// File: tb/tb_util_input_cond.sv
// Scoreboard bench for util_input_cond: a queue-based reference model predicts
// q/rise/fall/changed for every clock edge, and a monitor compares each cycle.
module tb_util_input_cond;

    localparam int         W    = 8;
    localparam int         SYNC = 2;
    localparam int         DEB  = 4;
    localparam logic [7:0] RES  = 8'hA5;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         changed;
    } exp_t;

    logic         clk = 1'b0;
    logic         res_n;
    logic         tick;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int tests = 0;
    int fails = 0;

    exp_t         sb[$];
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_q;
    int           m_ticks[W];
    logic [W-1:0] cur_d;

    util_input_cond #(
        .WIDTH           (W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .RES_VAL         (RES)
    ) dut (
        .clk     (clk),
        .res_n   (res_n),
        .tick    (tick),
        .d       (d),
        .q       (q),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        m_hist = {};
        repeat (SYNC) m_hist.push_back(RES);
        m_q = RES;
        for (int i = 0; i < W; i++) m_ticks[i] = 0;
    endtask

    // Reference: s is the d sampled SYNC edges ago; a channel accepts s once it
    // has disagreed with q for DEB consecutive ticks.
    task automatic modelStep(input logic [W-1:0] dv, input logic tv, input logic rv);
        exp_t         e;
        logic [W-1:0] s;
        e.rise = '0;
        e.fall = '0;
        if (!rv) begin
            modelReset();
        end else begin
            s = m_hist[SYNC-1];
            for (int i = 0; i < W; i++) begin
                if (s[i] == m_q[i]) begin
                    m_ticks[i] = 0;
                end else if (tv) begin
                    m_ticks[i] = m_ticks[i] + 1;
                    if (m_ticks[i] == DEB) begin
                        m_ticks[i] = 0;
                        m_q[i]     = s[i];
                        if (s[i]) e.rise[i] = 1'b1;
                        else      e.fall[i] = 1'b1;
                    end
                end
            end
            m_hist.push_front(dv);
            void'(m_hist.pop_back());
        end
        e.q       = m_q;
        e.changed = |(e.rise | e.fall);
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [W-1:0] dv, input logic tv, input logic rv);
        @(negedge clk);
        d     = dv;
        tick  = tv;
        res_n = rv;
        cur_d = dv;
        modelStep(dv, tv, rv);
    endtask

    task automatic assertResetAsync();
        applyStimulus(cur_d, 1'b1, 1'b0);
        #1;
        checkOutput("async_reset_q", q, RES);
        checkOutput("async_reset_edges", rise | fall, 8'h00);
        checkOutput("async_reset_changed", {7'b0, changed}, 8'h00);
    endtask

    // Drives dv for up to n edges and reports the first edge (1-based) that pulses channel ch.
    task automatic measureEdge(input logic [W-1:0] dv, input int ch, input int n, output int lat);
        lat = 0;
        for (int k = 1; k <= n; k++) begin
            applyStimulus(dv, 1'b1, 1'b1);
            @(posedge clk);
            #2;
            if (lat == 0 && (rise[ch] || fall[ch])) lat = k;
        end
    endtask

    // Monitor: every output cycle is compared against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("q", q, e.q);
                checkOutput("rise", rise, e.rise);
                checkOutput("fall", fall, e.fall);
                checkOutput("changed", {7'b0, changed}, {7'b0, e.changed});
                checkOutput("rise_and_fall", rise & fall, 8'h00);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           lat;
        int           hits;
        logic         q3_before;
        logic [W-1:0] nd;
        logic         tv;

        d     = RES;
        tick  = 1'b1;
        res_n = 1'b0;
        cur_d = RES;
        modelReset();

        repeat (3) applyStimulus(RES, 1'b1, 1'b0);
        checkOutput("reset_q", q, RES);
        repeat (8) applyStimulus(RES, 1'b1, 1'b1);

        // Latency from the first sampling edge to the accept on channel 0.
        measureEdge(RES ^ 8'h01, 0, 20, lat);
        checkOutput("latency_ch0", 8'(lat), 8'(SYNC + DEB));
        checkOutput("q0_after_accept", {7'b0, q[0]}, {7'b0, ~RES[0]});

        // Short glitch on channel 3 must be rejected.
        q3_before = q[3];
        repeat (3) applyStimulus(cur_d ^ 8'h08, 1'b1, 1'b1);
        repeat (10) applyStimulus(cur_d ^ 8'h08, 1'b1, 1'b1);
        checkOutput("glitch_q3", {7'b0, q[3]}, {7'b0, q3_before});

        // Tick every 4th cycle on a channel 1 change.
        nd = cur_d ^ 8'h02;
        for (int k = 0; k < 40; k++) applyStimulus(nd, (k % 4) == 3, 1'b1);

        // All channels flip together and pulse in the same cycle.
        assertResetAsync();
        applyStimulus(RES, 1'b1, 1'b0);
        repeat (6) applyStimulus(RES, 1'b1, 1'b1);
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(~RES, 1'b1, 1'b1);
            @(posedge clk);
            #2;
            if ((rise | fall) == 8'hFF) hits++;
        end
        checkOutput("all_edges_once", 8'(hits), 8'd1);
        checkOutput("all_q_flipped", q, ~RES);

        // Reset in the middle of a count on channel 2: full count needed after release.
        assertResetAsync();
        applyStimulus(RES, 1'b1, 1'b0);
        repeat (4) applyStimulus(RES, 1'b1, 1'b1);
        repeat (4) applyStimulus(RES ^ 8'h04, 1'b1, 1'b1);
        assertResetAsync();
        applyStimulus(RES ^ 8'h04, 1'b1, 1'b0);
        measureEdge(RES ^ 8'h04, 2, 20, lat);
        checkOutput("latency_after_reset", 8'(lat), 8'(SYNC + DEB));

        // Random bouncing with random ticks and rare resets.
        for (int k = 0; k < 10000; k++) begin
            nd = cur_d ^ (8'($urandom) & 8'($urandom));
            tv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1999) == 0) begin
                applyStimulus(nd, tv, 1'b0);
                applyStimulus(nd, tv, 1'b0);
            end else begin
                applyStimulus(nd, tv, 1'b1);
            end
        end

        @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", 8'(sb.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
